// File: rtl/cdb_broadcaster_pkg.sv
// rtl/cdb_broadcaster_pkg.sv - shared lane indices and broadcast packet type for the CDB broadcaster
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package cdb_broadcaster_pkg;

    localparam int NUM_LANES = 4;
    localparam int FU_LSU    = 0;
    localparam int FU_MULT   = 1;
    localparam int FU_BTU    = 2;
    localparam int FU_ALU    = 3;

    typedef struct packed {
        logic [`ROB_TAG_LEN-1:0] tag;
        logic [`XLEN-1:0]        value;
    } CDB_PACKET;

endpackage

// File: rtl/cdb_broadcaster_if.sv
// rtl/cdb_broadcaster_if.sv - FU result handshake and wakeup broadcast bundle
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

interface cdb_broadcaster_if;

    logic [3:0]                         fu_valid;
    logic [3:0][`ROB_TAG_LEN-1:0]       fu_tag;
    logic [3:0][`XLEN-1:0]              fu_value;
    logic [3:0]                         fu_ready;
    logic                               flush;
    logic [3:0]                         wakeup;
    logic [3:0][`ROB_TAG_LEN-1:0]       wakeup_tag;
    logic [3:0][`XLEN-1:0]              wakeup_value;

    modport master (
        output fu_valid, fu_tag, fu_value, flush,
        input  fu_ready, wakeup, wakeup_tag, wakeup_value
    );

    modport slave (
        input  fu_valid, fu_tag, fu_value, flush,
        output fu_ready, wakeup, wakeup_tag, wakeup_value
    );

endinterface

// File: rtl/cdb_lane_fifo.sv
// rtl/cdb_lane_fifo.sv - per-lane in-order result FIFO with flush
module cdb_lane_fifo
    import cdb_broadcaster_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    input  logic      push,
    input  logic      pop,
    input  CDB_PACKET din,
    output logic      full,
    output logic      empty,
    output CDB_PACKET head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    CDB_PACKET       mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]     count_q, count_d;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// rtl/cdb_broadcaster.sv - round-robin CDB arbiter over four FU result FIFOs; CDB_BYPASS_EN enables same-cycle bypass
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int LANE_DEPTH = 4,
    parameter int CDB_WIDTH  = 2
) (
    input  logic             clk,
    input  logic             reset,
    cdb_broadcaster_if.slave bus
);

    logic [NUM_LANES-1:0] full, empty, push, pop, grant, bypass_cand, eligible;
    logic [NUM_LANES-1:0] wakeup_q, wakeup_d;
    CDB_PACKET            head   [NUM_LANES];
    CDB_PACKET            in_pkt [NUM_LANES];
    CDB_PACKET            pkt_q  [NUM_LANES];
    CDB_PACKET            pkt_d  [NUM_LANES];
    logic [1:0]           rr_q, rr_d, lane, last_lane;
    logic [2:0]           gnt_cnt;
    logic                 any_gnt;

`ifdef CDB_BYPASS_EN
    assign bypass_cand = empty & bus.fu_valid;
`else
    assign bypass_cand = '0;
`endif
    assign eligible     = ~empty | bypass_cand;
    assign bus.fu_ready = ~full;

    always_comb begin
        grant     = '0;
        gnt_cnt   = '0;
        any_gnt   = 1'b0;
        last_lane = rr_q;
        lane      = rr_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane = rr_q + 2'(k);
            if (!bus.flush && eligible[lane] && gnt_cnt < 3'(CDB_WIDTH)) begin
                grant[lane] = 1'b1;
                gnt_cnt     = gnt_cnt + 3'd1;
                last_lane   = lane;
                any_gnt     = 1'b1;
            end
        end
        rr_d = bus.flush ? 2'd0 : (any_gnt ? last_lane + 2'd1 : rr_q);
    end

    // A granted lane whose FIFO is empty can only be a bypass grant: it pops nothing and skips the write.
    assign pop  = grant & ~empty;
    assign push = bus.fu_valid & ~full & ~(grant & empty) & {NUM_LANES{~bus.flush}};

    always_comb begin
        wakeup_d = grant;
        for (int j = 0; j < NUM_LANES; j++) begin
            in_pkt[j] = '{tag: bus.fu_tag[j], value: bus.fu_value[j]};
            pkt_d[j]  = '0;
            if (grant[j]) pkt_d[j] = empty[j] ? in_pkt[j] : head[j];
        end
    end

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        cdb_lane_fifo #(.DEPTH(LANE_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (bus.flush),
            .push  (push[j]),
            .pop   (pop[j]),
            .din   (in_pkt[j]),
            .full  (full[j]),
            .empty (empty[j]),
            .head  (head[j])
        );
        assign bus.wakeup_tag[j]   = pkt_q[j].tag;
        assign bus.wakeup_value[j] = pkt_q[j].value;
    end

    assign bus.wakeup = wakeup_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q     <= '0;
            wakeup_q <= '0;
            for (int j = 0; j < NUM_LANES; j++) pkt_q[j] <= '0;
        end else begin
            rr_q     <= rr_d;
            wakeup_q <= wakeup_d;
            for (int j = 0; j < NUM_LANES; j++) pkt_q[j] <= pkt_d[j];
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb/tb_cdb_broadcaster.sv - directed and random checks of cdb_broadcaster against a queue-based model
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_cdb_broadcaster;

    localparam int T   = `ROB_TAG_LEN;
    localparam int X   = `XLEN;
    localparam int PKT = T + X;
    localparam int LANE_DEPTH = 4;
    localparam int CDB_WIDTH  = 2;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
    localparam int LAT = 0;
`else
    localparam bit BYP = 1'b0;
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cdb_broadcaster_if bus ();

    cdb_broadcaster #(.LANE_DEPTH(LANE_DEPTH), .CDB_WIDTH(CDB_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [PKT-1:0]        mq [4][$];
    int                    m_rr;
    logic [3:0]            exp_wk;
    logic [3:0][T-1:0]     exp_tag;
    logic [3:0][X-1:0]     exp_val;
    logic [3:0][T-1:0]     cur_tag;
    logic [3:0][X-1:0]     cur_val;
    logic [3:0]            hist [$];
    logic [3:0][T-1:0]     htag [$];
    logic [3:0][X-1:0]     hval [$];
    logic                  saw_full1;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 4; j++) mq[j].delete();
        m_rr = 0;
    endtask

    task automatic model_step(input logic [3:0] v, input logic fl);
        logic [3:0]     rdy, byp;
        logic [PKT-1:0] p;
        int cnt, last, ln;
        bit any;
        exp_wk = '0; exp_tag = '0; exp_val = '0; byp = '0;
        cnt = 0; last = 0; any = 0;
        for (int j = 0; j < 4; j++) rdy[j] = (mq[j].size() < LANE_DEPTH);
        if (fl) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                ln = (m_rr + k) % 4;
                if ((mq[ln].size() > 0 || (BYP && v[ln])) && cnt < CDB_WIDTH) begin
                    if (mq[ln].size() > 0) p = mq[ln].pop_front();
                    else begin
                        p = {cur_tag[ln], cur_val[ln]};
                        byp[ln] = 1'b1;
                    end
                    exp_wk[ln]  = 1'b1;
                    exp_tag[ln] = p[PKT-1 -: T];
                    exp_val[ln] = p[X-1:0];
                    cnt++; last = ln; any = 1;
                end
            end
            if (any) m_rr = (last + 1) % 4;
            for (int j = 0; j < 4; j++)
                if (v[j] && rdy[j] && !byp[j]) mq[j].push_back({cur_tag[j], cur_val[j]});
        end
    endtask

    task automatic step(input logic [3:0] v, input logic fl);
        logic [3:0] er;
        bus.fu_valid = v;
        bus.fu_tag   = cur_tag;
        bus.fu_value = cur_val;
        bus.flush    = fl;
        #1;
        for (int j = 0; j < 4; j++) er[j] = (mq[j].size() < LANE_DEPTH);
        chk("fu_ready", bus.fu_ready, er);
        if (bus.fu_ready[1] === 1'b0) saw_full1 = 1'b1;
        model_step(v, fl);
        @(posedge clk);
        #1;
        chk("wakeup", bus.wakeup, exp_wk);
        chk("wakeup_tag", bus.wakeup_tag, exp_tag);
        chk("wakeup_value", bus.wakeup_value, exp_val);
        hist.push_back(bus.wakeup);
        htag.push_back(bus.wakeup_tag);
        hval.push_back(bus.wakeup_value);
    endtask

    task automatic randomize_inputs();
        for (int j = 0; j < 4; j++) begin
            cur_tag[j] = T'($urandom);
            cur_val[j] = X'($urandom);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.fu_valid = '0; bus.fu_tag = '0; bus.fu_value = '0; bus.flush = 1'b0;
        cur_tag = '0; cur_val = '0; saw_full1 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wakeup", bus.wakeup, 4'b0000);
        chk("reset_value", bus.wakeup_value, '0);
        reset = 1'b0;
        #1;
        chk("reset_ready", bus.fu_ready, 4'b1111);

        // single ALU result
        hist.delete(); htag.delete(); hval.delete();
        cur_tag[3] = T'(5); cur_val[3] = X'(32'hDEAD);
        step(4'b1000, 1'b0);
        cur_tag = '0; cur_val = '0;
        repeat (3) step(4'b0000, 1'b0);
        chk("single_wakeup", hist[LAT], 4'b1000);
        chk("single_tag", htag[LAT][3], 5);
        chk("single_value", hval[LAT][3], 32'hDEAD);
        chk("single_after", hist[LAT+1], 4'b0000);

        // contention, twice to confirm rr_ptr returns to lane 0
        for (int r = 0; r < 2; r++) begin
            hist.delete(); htag.delete(); hval.delete();
            randomize_inputs();
            step(4'b1111, 1'b0);
            repeat (3) step(4'b0000, 1'b0);
            chk("contend_first", hist[LAT], 4'b0011);
            chk("contend_second", hist[LAT+1], 4'b1100);
            chk("contend_idle", hist[LAT+2], 4'b0000);
        end

        // backpressure: all lanes streaming, arbitration cannot keep up
        for (int c = 0; c < 16; c++) begin
            randomize_inputs();
            step(4'b1111, 1'b0);
        end
        chk("mult_backpressure_seen", saw_full1, 1'b1);
        repeat (3) step(4'b0000, 1'b0);

        // flush with buffered results and fresh valid inputs
        randomize_inputs();
        step(4'b1111, 1'b1);
        hist.delete();
        repeat (4) step(4'b0000, 1'b0);
        foreach (hist[k]) chk("post_flush_quiet", hist[k], 4'b0000);

        // wrap-around: ten back-to-back results on LSU
        hist.delete(); htag.delete(); hval.delete();
        for (int i = 0; i < 10; i++) begin
            cur_tag[0] = T'(i); cur_val[0] = X'(i * 3);
            step(4'b0001, 1'b0);
        end
        repeat (4) step(4'b0000, 1'b0);
        n = 0;
        foreach (hist[k]) if (hist[k][0]) begin
            chk("wrap_order", htag[k][0], n);
            n++;
        end
        chk("wrap_count", n, 10);

        // random traffic with occasional flush
        for (int c = 0; c < 300; c++) begin
            randomize_inputs();
            step(4'($urandom), ($urandom_range(0, 31) == 0));
        end

        // asynchronous reset between clock edges while broadcasting
        randomize_inputs();
        step(4'b1111, 1'b0);
        step(4'b0000, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_wakeup", bus.wakeup, 4'b0000);
        chk("async_reset_tag", bus.wakeup_tag, '0);
        chk("async_reset_value", bus.wakeup_value, '0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            randomize_inputs();
            step(4'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_broadcaster.md
CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

Interface
REQ-001 SHALL have parameter LANE_DEPTH, default 4, meaning entries per FU result FIFO (power of 2, >=2).
REQ-002 SHALL have parameter CDB_WIDTH, default 2, meaning maximum lanes broadcast per cycle (1..4).
REQ-003 SHALL have port clk  input  1  system clock, all state on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fu_valid  input  [3:0]  per-lane result valid, lane order [FU_LSU, FU_MULT, FU_BTU, FU_ALU] = [0..3].
REQ-006 SHALL have port fu_tag  input  [3:0][`ROB_TAG_LEN-1:0]  per-lane completed ROB tag.
REQ-007 SHALL have port fu_value  input  [3:0][`XLEN-1:0]  per-lane result value.
REQ-008 SHALL have port fu_ready  output  [3:0]  per-lane accept; a transfer occurs when fu_valid[j] && fu_ready[j].
REQ-009 SHALL have port flush  input  1  squash all buffered and in-flight results.
REQ-010 SHALL have port wakeup  output  [3:0]  registered per-lane broadcast strobe to reservation stations and ROB.
REQ-011 SHALL have port wakeup_tag  output  [3:0][`ROB_TAG_LEN-1:0]  registered broadcast tag per lane.
REQ-012 SHALL have port wakeup_value  output  [3:0][`XLEN-1:0]  registered broadcast value per lane.

Function
REQ-013 SHALL buffer each lane's accepted results in order in its own FIFO of LANE_DEPTH entries.
REQ-014 SHALL drive fu_ready[j] = FIFO j not full, from registered count only; a full FIFO stays not-ready even if its head pops this cycle.
REQ-015 SHALL each cycle grant up to CDB_WIDTH non-empty lanes, scanning lanes rr_ptr, rr_ptr+1, ... mod 4.
REQ-016 SHALL pop the head of each granted lane and register it: wakeup[j] <= 1, wakeup_tag[j]/wakeup_value[j] <= head tag/value.
REQ-017 SHALL drive wakeup[j] = 0 and wakeup_tag[j]/wakeup_value[j] = 0 next cycle for non-granted lanes.
REQ-018 SHALL update rr_ptr <= (highest-scanned granted lane + 1) mod 4 when any grant occurs, else hold.
REQ-019 SHALL allow push and pop on the same lane in one cycle; count unchanged, pointers wrap mod LANE_DEPTH.
REQ-020 SHALL, with flush high in cycle N, suppress all grants and pushes in N; at N+1 all FIFOs empty, wakeup = 0, rr_ptr = 0.
REQ-021 SHALL guarantee wakeup outputs are stable from posedge to posedge (no combinational path from any input).
REQ-022 SHALL give result latency (fu_valid accepted at N, empty FIFO, lane granted) of wakeup at N+2 (N+1 under CDB_BYPASS_EN).

Reset
REQ-023 SHALL on reset asynchronously clear all FIFO pointers/counts, rr_ptr = 0, wakeup = 0, wakeup_tag = 0, wakeup_value = 0.
REQ-024 SHALL drive fu_ready = 4'b1111 from the first cycle after reset deasserts; results in flight at reset are lost.

Configuration
REQ-025 SHALL support macro CDB_BYPASS_EN: when defined, a lane with empty FIFO and fu_valid high is arbitration-eligible the same cycle and its input is broadcast directly without being written to the FIFO.
REQ-026 SHALL, without CDB_BYPASS_EN, make only FIFO heads eligible; results always spend at least one cycle in the FIFO.
REQ-027 SHALL, with CDB_BYPASS_EN and a bypass candidate not granted, write it to the FIFO normally.

Structure
REQ-028 SHALL place FU lane index constants (FU_LSU=0, FU_MULT=1, FU_BTU=2, FU_ALU=3) and typedef CDB_PACKET {tag, value} in a shared package header.
REQ-029 SHALL implement each lane FIFO as sub-module cdb_lane_fifo (push, pop, full, empty, head), instantiated four times.

Verification
REQ-030 SHALL cover single result: ALU lane tag 5, value 0xDEAD at cycle 0 -> wakeup = 4'b1000, tag 5, value 0xDEAD at cycle 2 (cycle 1 with bypass), zero at cycle 3.
REQ-031 SHALL cover contention: CDB_WIDTH = 2, all four lanes one result each, rr_ptr = 0 -> lanes 0,1 broadcast first, lanes 2,3 next cycle, rr_ptr = 0 afterwards.
REQ-032 SHALL cover backpressure: MULT pushes 5 results with no grant possible -> fu_ready[1] = 0 after 4 accepted; 5th held, accepted after first pop, order preserved.
REQ-033 SHALL cover flush: 3 results buffered, flush 1 cycle with new fu_valid -> no wakeup ever for any of the 4 tags; fu_ready = 4'b1111 next cycle.
REQ-034 SHALL cover async reset mid-broadcast: reset asserted between edges -> wakeup = 0 immediately, not waiting for clk.
REQ-035 SHALL cover wrap-around: LANE_DEPTH = 4, 10 back-to-back results on one lane with simultaneous push/pop -> tags emerge in order, none lost or duplicated.
